// File: rtl/sifh_fsm_pkg.sv
// Shared definitions for the sifh_fsm histogram controller.
// Holds parameter defaults, the controller state enum, the no-photon code and
// a helper for counter/index widths.
package sifh_fsm_pkg;

  localparam int unsigned NpDef       = 10;
  localparam int unsigned NbDef       = 5;
  localparam int unsigned PeakMaxDef  = 8;
  localparam int unsigned AcqNumDef   = 8;
  localparam int unsigned PixelNumDef = 4;

  // TDC code meaning "no photon detected" (all ones) at the default width.
  localparam logic [NpDef-1:0] NoPhotonCode = '1;

  typedef enum logic [1:0] {
    StAccum,
    StDrain,
    StStore,
    StClear
  } state_e;

  // Width needed to index n items; at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sifh_peak_tracker.sv
// Peak-bin tracker for one pixel histogram.
// Keeps the largest bin count seen so far and its bin; a later bin replaces the
// peak only on a strictly greater count, so ties keep the earlier bin.
// Ports:
//   clk_i      clock
//   rst_ni     synchronous active-low reset
//   clr_i      restart tracking for the next pixel
//   upd_i      a histogram update is presented this cycle
//   upd_bin_i  bin being updated
//   upd_cnt_i  new count of that bin
//   result_o   {peak bin, zeros}, or all ones when no photon was counted
module sifh_peak_tracker #(
  parameter int unsigned NP       = 10,
  parameter int unsigned NB       = 5,
  parameter int unsigned PEAK_MAX = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                upd_i,
  input  logic [NB-1:0]       upd_bin_i,
  input  logic [PEAK_MAX-1:0] upd_cnt_i,
  output logic [NP-1:0]       result_o
);

  logic [PEAK_MAX-1:0] peak_cnt_q, peak_cnt_d;
  logic [NB-1:0]       peak_bin_q, peak_bin_d;
  logic                seen_q, seen_d;

  always_comb begin
    peak_cnt_d = peak_cnt_q;
    peak_bin_d = peak_bin_q;
    seen_d     = seen_q;
    if (clr_i) begin
      peak_cnt_d = '0;
      peak_bin_d = '1;
      seen_d     = 1'b0;
    end else if (upd_i) begin
      seen_d = 1'b1;
      if (upd_cnt_i > peak_cnt_q) begin
        peak_cnt_d = upd_cnt_i;
        peak_bin_d = upd_bin_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      peak_cnt_q <= '0;
      peak_bin_q <= '1;
      seen_q     <= 1'b0;
    end else begin
      peak_cnt_q <= peak_cnt_d;
      peak_bin_q <= peak_bin_d;
      seen_q     <= seen_d;
    end
  end

  assign result_o = seen_q ? {peak_bin_q, {(NP - NB){1'b0}}} : '1;

endmodule

// File: rtl/sifh_fsm.sv
// Per-pixel histogram controller for the dTOF pipeline.
// Accepts TDC timestamps, performs read-modify-write of bin counts in an external
// dual-port RAM, tracks the peak bin and publishes one peak timestamp per pixel.
// Optional feature: define SIFH_SAT_EN to saturate bin counts (no write when full);
// otherwise counts wrap.
// Ports:
//   clk, res (sync active-low)   clock and reset
//   wrEn, data                   timestamp strobe and value (all ones = no photon)
//   counts                       RAM port-b read data, one cycle after the read
//   newCounts, waddr, wEnable,   RAM port-a write data/address/write enable,
//   writeFlag                    memory enable
//   raddr, rEnable (active-low), RAM port-b address/read enable/memory enable
//   readFlag
//   peakResult                   per-pixel peak timestamp array
module sifh_fsm
  import sifh_fsm_pkg::*;
#(
  parameter int unsigned NP                = NpDef,
  parameter int unsigned NB                = NbDef,
  parameter int unsigned PEAK_MAX          = PeakMaxDef,
  parameter int unsigned ACQ_NUM           = AcqNumDef,
  parameter int unsigned PIXEL_NUM_PER_RAM = PixelNumDef
) (
  input  logic                                  clk,
  input  logic                                  res,
  input  logic                                  wrEn,
  input  logic [NP-1:0]                         data,
  input  logic [PEAK_MAX-1:0]                   counts,
  output logic [PEAK_MAX-1:0]                   newCounts,
  output logic [NB-1:0]                         waddr,
  output logic [NB-1:0]                         raddr,
  output logic                                  wEnable,
  output logic                                  rEnable,
  output logic                                  writeFlag,
  output logic                                  readFlag,
  output logic [PIXEL_NUM_PER_RAM-1:0][NP-1:0] peakResult
);

  localparam int unsigned CntW = idx_width(ACQ_NUM);
  localparam int unsigned PixW = idx_width(PIXEL_NUM_PER_RAM);

  state_e          state_q, state_d;
  logic [CntW-1:0] smp_q, smp_d;
  logic [PixW-1:0] pix_q, pix_d;
  logic [NB-1:0]   clr_q, clr_d;
  logic            tracker_clr;

  // Stage 1: read issued. Stage 2: count returned, update written.
  logic                rd_q, upd_q;
  logic [NB-1:0]       rbin_q, ubin_q;
  // Previous-cycle update, forwarded over the RAM's read-during-write hazard.
  logic                fwd_q;
  logic [NB-1:0]       fbin_q;
  logic [PEAK_MAX-1:0] fcnt_q;

  logic [PIXEL_NUM_PER_RAM-1:0][NP-1:0] peak_res_q;
  logic [NP-1:0]       peak_res;

  logic                accept, photon, upd_wr;
  logic [PEAK_MAX-1:0] cnt_cur, cnt_new;

  assign accept  = wrEn && (state_q == StAccum);
  assign photon  = accept && !(&data);
  assign cnt_cur = (fwd_q && (fbin_q == ubin_q)) ? fcnt_q : counts;

`ifdef SIFH_SAT_EN
  assign cnt_new = (&cnt_cur) ? cnt_cur : cnt_cur + 1'b1;
  assign upd_wr  = upd_q && !(&cnt_cur);
`else
  assign cnt_new = cnt_cur + 1'b1;
  assign upd_wr  = upd_q;
`endif

  always_comb begin
    state_d     = state_q;
    smp_d       = smp_q;
    pix_d       = pix_q;
    clr_d       = clr_q;
    tracker_clr = 1'b0;
    unique case (state_q)
      StAccum: begin
        if (wrEn) begin
          if (smp_q == CntW'(ACQ_NUM - 1)) begin
            smp_d   = '0;
            state_d = StDrain;
          end else begin
            smp_d = smp_q + 1'b1;
          end
        end
      end
      // Stage 2 always finishes in the cycle after stage 1, so an empty stage 1
      // means the peak registers are final by the next cycle.
      StDrain: if (!rd_q) state_d = StStore;
      StStore: begin
        state_d = StClear;
        pix_d   = (pix_q == PixW'(PIXEL_NUM_PER_RAM - 1)) ? '0 : pix_q + 1'b1;
      end
      StClear: begin
        clr_d = clr_q + 1'b1;
        if (&clr_q) begin
          state_d     = StAccum;
          tracker_clr = 1'b1;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q    <= StAccum;
      smp_q      <= '0;
      pix_q      <= '0;
      clr_q      <= '0;
      rd_q       <= 1'b0;
      rbin_q     <= '0;
      upd_q      <= 1'b0;
      ubin_q     <= '0;
      fwd_q      <= 1'b0;
      fbin_q     <= '0;
      fcnt_q     <= '0;
      peak_res_q <= '0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      pix_q   <= pix_d;
      clr_q   <= clr_d;
      rd_q    <= photon;
      if (photon) rbin_q <= data[NP-1 -: NB];
      upd_q   <= rd_q;
      if (rd_q) ubin_q <= rbin_q;
      fwd_q   <= upd_q;
      fbin_q  <= ubin_q;
      fcnt_q  <= cnt_new;
      if (state_q == StStore) peak_res_q[pix_q] <= peak_res;
    end
  end

  sifh_peak_tracker #(
    .NP       (NP),
    .NB       (NB),
    .PEAK_MAX (PEAK_MAX)
  ) u_peak (
    .clk_i     (clk),
    .rst_ni    (res),
    .clr_i     (tracker_clr),
    .upd_i     (upd_q),
    .upd_bin_i (ubin_q),
    .upd_cnt_i (cnt_new),
    .result_o  (peak_res)
  );

  assign raddr      = rbin_q;
  assign readFlag   = rd_q;
  assign rEnable    = ~rd_q;
  assign waddr      = (state_q == StClear) ? clr_q : ubin_q;
  assign wEnable    = (state_q == StClear) || upd_wr;
  assign writeFlag  = (state_q == StClear) || upd_wr;
  assign newCounts  = upd_q ? cnt_new : '0;
  assign peakResult = peak_res_q;

endmodule

// File: tb/tb_sifh_fsm.sv
// Self-checking bench for sifh_fsm: directed vector table, multi-cycle pixel
// sequences against a RAM model, reset abort, and randomized pixels checked
// against a histogram/peak reference model.
module tb_sifh_fsm;
  import sifh_fsm_pkg::*;

  logic                 clk = 1'b0;
  logic                 res = 1'b1;
  logic                 wrEn = 1'b0;
  logic [9:0]           data = '0;
  logic [7:0]           counts, newCounts;
  logic [4:0]           waddr, raddr;
  logic                 wEnable, rEnable, writeFlag, readFlag;
  logic [3:0][9:0]      peakResult;

  logic [7:0] counts_force = '0;
  logic [7:0] counts_ram = '0;
  logic       use_ram = 1'b0;
  logic       ram_zero = 1'b0;
  logic [7:0] ram [32];

  int n_run = 0;
  int n_fail = 0;
  int nreads;
  logic [12:0] wlog[$];

  always #5 clk = ~clk;

  sifh_fsm dut (
    .clk        (clk),
    .res        (res),
    .wrEn       (wrEn),
    .data       (data),
    .counts     (counts),
    .newCounts  (newCounts),
    .waddr      (waddr),
    .raddr      (raddr),
    .wEnable    (wEnable),
    .rEnable    (rEnable),
    .writeFlag  (writeFlag),
    .readFlag   (readFlag),
    .peakResult (peakResult)
  );

  // Dual-port RAM model: registered read returns old data on a same-edge write.
  always @(posedge clk) begin
    if (ram_zero) begin
      for (int i = 0; i < 32; i++) ram[i] <= '0;
    end else begin
      if (readFlag && !rEnable) counts_ram <= ram[raddr];
      if (writeFlag && wEnable) ram[waddr] <= newCounts;
    end
  end
  assign counts = use_ram ? counts_ram : counts_force;

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, then observe RAM traffic.
  task automatic cyc(input logic w, input logic [9:0] d, input logic [7:0] c);
    @(posedge clk);
    #1;
    wrEn = w;
    data = d;
    counts_force = c;
    #1;
    if (wEnable && writeFlag) wlog.push_back({waddr, newCounts});
    if (readFlag) nreads++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    res = 1'b0;
    wrEn = 1'b0;
    @(posedge clk);
    #1;
    res = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".rEnable"}, int'(rEnable), 1);
    chk({tag, ".readFlag"}, int'(readFlag), 0);
    chk({tag, ".wEnable"}, int'(wEnable), 0);
    chk({tag, ".writeFlag"}, int'(writeFlag), 0);
    chk({tag, ".newCounts"}, int'(newCounts), 0);
    chk({tag, ".raddr"}, int'(raddr), 0);
    chk({tag, ".waddr"}, int'(waddr), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("%s.peak%0d", tag, i), int'(peakResult[i]), 0);
  endtask

  task automatic zero_ram();
    ram_zero = 1'b1;
    cyc(1'b0, '0, '0);
    ram_zero = 1'b0;
  endtask

  function automatic int ram_nonzero();
    int n = 0;
    for (int i = 0; i < 32; i++) if (ram[i] != 0) n++;
    return n;
  endfunction

  typedef struct {
    logic       wr;
    logic [9:0] d;
    logic [7:0] c;
    logic       rd;
    logic [4:0] ra;
    logic       we;
    logic [4:0] wa;
    logic [7:0] nc;
  } vec_t;

  vec_t tbl[12];
  int   exp_peak[4];
  int   hist[32];

  initial begin
    logic [9:0] noph;
    logic [12:0] e;
    noph = NoPhotonCode;

    // Reset state
    do_reset();
    chk_reset_outputs("reset");

    // Directed vectors with forced read data
    tbl[0]  = '{1'b1, 10'd108,  8'd0,   1'b0, 5'd0,  1'b0, 5'd0,  8'd0};
    tbl[1]  = '{1'b0, 10'd0,    8'd0,   1'b1, 5'd3,  1'b0, 5'd0,  8'd0};
    tbl[2]  = '{1'b0, 10'd0,    8'd0,   1'b0, 5'd0,  1'b1, 5'd3,  8'd1};
    tbl[3]  = '{1'b1, 10'd1022, 8'd0,   1'b0, 5'd0,  1'b0, 5'd0,  8'd0};
    tbl[4]  = '{1'b1, 10'd1022, 8'd0,   1'b1, 5'd31, 1'b0, 5'd0,  8'd0};
    tbl[5]  = '{1'b0, 10'd0,    8'd0,   1'b1, 5'd31, 1'b1, 5'd31, 8'd1};
    tbl[6]  = '{1'b0, 10'd0,    8'd0,   1'b0, 5'd0,  1'b1, 5'd31, 8'd2};
    tbl[7]  = '{1'b1, noph,     8'd7,   1'b0, 5'd0,  1'b0, 5'd0,  8'd0};
    tbl[8]  = '{1'b1, 10'd0,    8'd9,   1'b0, 5'd0,  1'b0, 5'd0,  8'd0};
    tbl[9]  = '{1'b0, 10'd0,    8'd9,   1'b1, 5'd0,  1'b0, 5'd0,  8'd0};
`ifdef SIFH_SAT_EN
    tbl[10] = '{1'b0, 10'd0,    8'd255, 1'b0, 5'd0,  1'b0, 5'd0,  8'd255};
`else
    tbl[10] = '{1'b0, 10'd0,    8'd255, 1'b0, 5'd0,  1'b1, 5'd0,  8'd0};
`endif
    tbl[11] = '{1'b0, 10'd0,    8'd5,   1'b0, 5'd0,  1'b0, 5'd0,  8'd0};
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].wr, tbl[i].d, tbl[i].c);
      chk($sformatf("tbl%0d.readFlag", i), int'(readFlag), int'(tbl[i].rd));
      chk($sformatf("tbl%0d.rEnable", i), int'(rEnable), int'(!tbl[i].rd));
      chk($sformatf("tbl%0d.wEnable", i), int'(wEnable), int'(tbl[i].we));
      chk($sformatf("tbl%0d.writeFlag", i), int'(writeFlag), int'(tbl[i].we));
      chk($sformatf("tbl%0d.newCounts", i), int'(newCounts), int'(tbl[i].nc));
      if (tbl[i].rd) chk($sformatf("tbl%0d.raddr", i), int'(raddr), int'(tbl[i].ra));
      if (tbl[i].we) chk($sformatf("tbl%0d.waddr", i), int'(waddr), int'(tbl[i].wa));
    end

    // Full pixel against the RAM model, then the 32-bin clear
    do_reset();
    chk_reset_outputs("reset2");
    use_ram = 1'b1;
    zero_ram();
    wlog.delete();
    cyc(1'b1, 10'd200, '0);
    cyc(1'b1, 10'd200, '0);
    cyc(1'b1, 10'd90, '0);
    for (int i = 0; i < 5; i++) cyc(1'b1, noph, '0);
    for (int i = 0; i < 35; i++) cyc(1'b0, '0, '0);
    chk("full.peak0", int'(peakResult[0]), 192);
    chk("full.nwrites", wlog.size(), 35);
    if (wlog.size() == 35) begin
      chk("full.w0", int'(wlog[0]), int'({5'd6, 8'd1}));
      chk("full.w1", int'(wlog[1]), int'({5'd6, 8'd2}));
      chk("full.w2", int'(wlog[2]), int'({5'd2, 8'd1}));
      for (int i = 0; i < 32; i++) begin
        e = {5'(i), 8'd0};
        chk($sformatf("full.clr%0d", i), int'(wlog[3 + i]), int'(e));
      end
    end
    cyc(1'b0, '0, '0);
    chk("full.ram_clear", ram_nonzero(), 0);

    // All-no-photon pixel lands in pixel 1
    nreads = 0;
    for (int i = 0; i < 8; i++) cyc(1'b1, noph, '0);
    for (int i = 0; i < 35; i++) cyc(1'b0, '0, '0);
    chk("empty.reads", nreads, 0);
    chk("empty.peak1", int'(peakResult[1]), 1023);
    chk("empty.peak0", int'(peakResult[0]), 192);

    // Reset in the middle of accumulation
    cyc(1'b1, 10'd300, '0);
    cyc(1'b1, 10'd301, '0);
    cyc(1'b1, 10'd64, '0);
    do_reset();
    chk_reset_outputs("midreset");

    // Randomized pixels against the histogram reference model
    zero_ram();
    for (int i = 0; i < 4; i++) exp_peak[i] = 0;
    for (int p = 0; p < 12; p++) begin
      int best, bestbin, nsmp;
      bit any;
      logic [9:0] d;
      if (p > 0) chk($sformatf("rnd%0d.ram_clear", p), ram_nonzero(), 0);
      for (int b = 0; b < 32; b++) hist[b] = 0;
      best = 0;
      bestbin = 0;
      any = 1'b0;
      nsmp = 0;
      while (nsmp < 8) begin
        if (nsmp > 0 && $urandom_range(0, 3) == 0) begin
          cyc(1'b0, '0, '0);
        end else begin
          if ($urandom_range(0, 9) < 3) d = noph;
          else d = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
          if (d != noph) begin
            hist[d >> 5] = (hist[d >> 5] + 1) % 256;
            any = 1'b1;
            if (hist[d >> 5] > best) begin
              best = hist[d >> 5];
              bestbin = int'(d >> 5);
            end
          end
          cyc(1'b1, d, '0);
          nsmp++;
        end
      end
      exp_peak[p % 4] = any ? bestbin * 32 : 1023;
      for (int i = 0; i < 35; i++) cyc(1'b0, '0, '0);
      for (int i = 0; i < 4; i++)
        chk($sformatf("rnd%0d.peak%0d", p, i), int'(peakResult[i]), exp_peak[i]);
    end
    cyc(1'b0, '0, '0);
    chk("rnd.ram_clear_end", ram_nonzero(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sifh_fsm.md
# sifh_fsm

Per-pixel histogram controller for the dTOF pipeline: accepts TDC timestamps, runs a read-modify-write histogram in an external dual-port bin RAM, tracks the peak bin per pixel, and publishes one peak timestamp per pixel. It sits between the TDC/acquisition front end and the depth-readout logic, owning the RAM's address and enable ports.

## Interface
Parameters:
- NP, 10: TDC timestamp width.
- NB, 5: bin address width; bin = data[NP-1 -: NB].
- PEAK_MAX, 8: bin counter width.
- ACQ_NUM, 8: accepted samples per pixel histogram.
- PIXEL_NUM_PER_RAM, 4: pixels sharing one RAM; peakResult depth.

Ports (one clock; reset synchronous, active-low):
- clk  in  1  clock.
- res  in  1  synchronous active-low reset.
- wrEn  in  1  data valid.
- data  in  NP  timestamp; all-ones = no-photon code.
- counts  in  PEAK_MAX  RAM port-b read data, valid the cycle after a read.
- newCounts  out  PEAK_MAX  RAM port-a write data.
- waddr  out  NB  port-a address.
- raddr  out  NB  port-b address.
- wEnable  out  1  port-a write enable, active-high.
- rEnable  out  1  port-b read enable, active-low.
- writeFlag  out  1  port-a memory enable, active-high.
- readFlag  out  1  port-b memory enable, active-high.
- peakResult  out  NP x PIXEL_NUM_PER_RAM  per-pixel peak timestamp array.

## Operation
- States: ACCUM, DRAIN, STORE, CLEAR. Reset -> ACCUM, pixel 0, sample count 0, peak count 0, peak bin all-ones.
- ACCUM: each wrEn=1 cycle counts one sample. Photon sample (data != all-ones) issues a histogram read of its bin. No-photon sample counts toward ACQ_NUM, no RAM access.
- Update: newCounts = counts + 1 (see Configuration); written to same bin. If newCounts > peak count (strict), peak count/bin updated; ties keep earlier bin.
- Forwarding: if update bin equals bin written the previous cycle, the previous newCounts replaces counts.
- After the ACQ_NUM-th sample: DRAIN until the pipeline is empty, then STORE.
- STORE (1 cycle): peakResult[pixel] = {peak bin, NP-NB zeros}; all-ones if no photon was counted. Pixel increments, wrapping at PIXEL_NUM_PER_RAM.
- CLEAR: writes 0 to bins 0..2^NB-1, one per cycle (wEnable=1, writeFlag=1), then ACCUM with counters and peak reset.
- wrEn ignored in DRAIN, STORE, CLEAR; upstream must hold off for 2^NB+3 cycles after the last sample.

## Timing
- Sample at cycle t; raddr, readFlag=1, rEnable=0 at t+1 (registered).
- counts arrives at t+2; newCounts/waddr/wEnable/writeFlag asserted at t+2; peak registers update at t+3.
- Back-to-back samples: one per cycle, no stalls.
- Reset values: newCounts 0, waddr 0, raddr 0, wEnable 0, rEnable 1, writeFlag 0, readFlag 0, peakResult all 0.
- res low mid-operation aborts any state in one cycle; RAM contents are not cleared by reset.

## Configuration
- SIFH_SAT_EN defined: counts saturate at 2^PEAK_MAX-1; a saturated bin issues no write.
- Undefined: counts wrap modulo 2^PEAK_MAX; the wrapped value is written and compared normally.

## Structure
- Shared package: parameter defaults, state enum, no-photon code constant.
- One sub-module, sifh_peak_tracker: holds peak count/bin, strict-greater compare, all-ones-on-empty result. FSM, address pipeline and forwarding stay in the top.

## Test plan
- Reset: res=0 one cycle -> rEnable=1, all other outputs 0, peakResult all 0.
- Single sample data=108 -> raddr=3 at t+1 with rEnable=0; with counts=0 at t+2, waddr=3, newCounts=1, wEnable=1.
- Back-to-back data=1022 twice, counts=0 both reads -> second write newCounts=2 via forwarding.
- Full pixel: 8 samples (200,200,90,1023,1023,1023,1023,1023), RAM model -> peakResult[0]=192, then 32 CLEAR writes of 0.
- All-no-photon pixel: 8 x data=1023 -> no reads, peakResult[pixel]=1023.
- Saturation: with SIFH_SAT_EN, counts=255 -> no write; without, newCounts=0.
